// File: rtl/float_mul_arbiter.sv
// float_mul_arbiter: shares one IEEE-754 single-precision multiplier core
// among NUM_REQ requesters, one operation in flight at a time. Operands and
// products pass through untouched.
// Build option: define FMUL_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority (lowest index wins) with no pointer logic.
module float_mul_arbiter #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [32*NUM_REQ-1:0] req_a,
   input  logic [32*NUM_REQ-1:0] req_b,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [31:0]           rsp_z,
   output logic [NUM_REQ-1:0]    rsp_valid,
   input  logic [NUM_REQ-1:0]    rsp_ready,
   output logic [31:0]           mul_a,
   output logic [31:0]           mul_b,
   output logic                  mul_ab_stb,
   input  logic                  mul_ab_ack,
   input  logic [31:0]           mul_z,
   input  logic                  mul_z_stb,
   output logic                  mul_z_ack,
   output logic                  busy,
   output logic [2:0]            grant_id
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_Z, RESP} state_t;

   state_t               state;
   logic [2:0]           win_idx;
   logic                 win_found;
   logic [31:0]          win_a;
   logic [31:0]          win_b;
   logic [NUM_REQ-1:0]   owner_oh;
`ifdef FMUL_ARB_RR_EN
   logic [2:0]           rr_ptr;
`endif

   // Pick the arbitration winner among pending requesters
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
`ifdef FMUL_ARB_RR_EN
      // Two passes emulate a search starting at rr_ptr+1 and wrapping to 0.
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (!win_found && req_valid[j] && (3'(j) > rr_ptr)) begin
            win_idx   = 3'(j);
            win_found = 1'b1;
         end
      end
`endif
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (!win_found && req_valid[j]) begin
            win_idx   = 3'(j);
            win_found = 1'b1;
         end
      end
   end

   // Select the winner's operands and decode the handshake vectors
   always_comb begin
      win_a     = '0;
      win_b     = '0;
      req_ready = '0;
      owner_oh  = '0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (win_idx == 3'(j)) begin
            win_a = req_a[32*j +: 32];
            win_b = req_b[32*j +: 32];
            if ((state == IDLE) && win_found) begin
               req_ready[j] = 1'b1;
            end
         end
         if (grant_id == 3'(j)) begin
            owner_oh[j] = 1'b1;
         end
      end
   end

   assign busy = (state != IDLE);

   // Operation sequencer: accept, issue to core, wait for product, respond
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         mul_ab_stb <= 1'b0;
         mul_z_ack  <= 1'b0;
         rsp_valid  <= '0;
         mul_a      <= '0;
         mul_b      <= '0;
         rsp_z      <= '0;
         grant_id   <= '0;
`ifdef FMUL_ARB_RR_EN
         rr_ptr     <= 3'(NUM_REQ - 1);
`endif
      end else begin
         mul_z_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  mul_a      <= win_a;
                  mul_b      <= win_b;
                  grant_id   <= win_idx;
                  mul_ab_stb <= 1'b1;
                  state      <= ISSUE;
`ifdef FMUL_ARB_RR_EN
                  rr_ptr     <= win_idx;
`endif
               end
            end
            ISSUE: begin
               if (mul_ab_ack) begin
                  mul_ab_stb <= 1'b0;
                  state      <= WAIT_Z;
               end
            end
            WAIT_Z: begin
               if (mul_z_stb) begin
                  rsp_z     <= mul_z;
                  mul_z_ack <= 1'b1;
                  rsp_valid <= owner_oh;
                  state     <= RESP;
               end
            end
            RESP: begin
               // rsp_valid is one-hot on the owner, so this masks non-owner readies.
               if (|(rsp_ready & rsp_valid)) begin
                  rsp_valid <= '0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_float_mul_arbiter.sv
// Directed self-checking bench for float_mul_arbiter (NUM_REQ = 4). The bench
// plays the multiplier core and all requesters; it drives and samples on the
// falling clock edge.
module tb_float_mul_arbiter;

   logic         clk = 1'b0;
   logic         rstn;
   logic [127:0] req_a;
   logic [127:0] req_b;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [31:0]  rsp_z;
   logic [3:0]   rsp_valid;
   logic [3:0]   rsp_ready;
   logic [31:0]  mul_a;
   logic [31:0]  mul_b;
   logic         mul_ab_stb;
   logic         mul_ab_ack;
   logic [31:0]  mul_z;
   logic         mul_z_stb;
   logic         mul_z_ack;
   logic         busy;
   logic [2:0]   grant_id;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   float_mul_arbiter #(.NUM_REQ(4)) dut (
      .clk(clk), .rstn(rstn),
      .req_a(req_a), .req_b(req_b), .req_valid(req_valid), .req_ready(req_ready),
      .rsp_z(rsp_z), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .mul_a(mul_a), .mul_b(mul_b), .mul_ab_stb(mul_ab_stb), .mul_ab_ack(mul_ab_ack),
      .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
      .busy(busy), .grant_id(grant_id)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int p, input logic [31:0] a, input logic [31:0] b);
      req_a[32*p +: 32] = a;
      req_b[32*p +: 32] = b;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"},      busy,       0);
      chk({tag, "_stb"},       mul_ab_stb, 0);
      chk({tag, "_zack"},      mul_z_ack,  0);
      chk({tag, "_rsp_valid"}, rsp_valid,  0);
      chk({tag, "_mul_a"},     mul_a,      0);
      chk({tag, "_mul_b"},     mul_b,      0);
      chk({tag, "_rsp_z"},     rsp_z,      0);
      chk({tag, "_grant_id"},  grant_id,   0);
      chk({tag, "_req_ready"}, req_ready,  0);
   endtask

   // Serve one operation expected to be won by port p; called on a falling
   // edge in IDLE with the requests already presented.
   task automatic run_op(input int p, input logic [31:0] z, input int ack_dly,
                         input int rsp_dly, input bit drop);
      logic [3:0]  oh;
      logic [31:0] ea;
      logic [31:0] eb;
      oh = 4'b0001 << p;
      ea = req_a[32*p +: 32];
      eb = req_b[32*p +: 32];
      #1;
      chk("req_ready_winner", req_ready, oh);
      @(negedge clk);
      if (drop) req_valid[p] = 1'b0;
      chk("issue_stb",      mul_ab_stb, 1);
      chk("issue_grant_id", grant_id,   p);
      chk("issue_mul_a",    mul_a,      ea);
      chk("issue_mul_b",    mul_b,      eb);
      chk("issue_busy",     busy,       1);
      chk("issue_req_ready", req_ready, 0);
      for (int i = 0; i < ack_dly; i++) begin
         @(negedge clk);
         chk("slow_stb",   mul_ab_stb, 1);
         chk("slow_mul_a", mul_a,      ea);
         chk("slow_mul_b", mul_b,      eb);
      end
      mul_ab_ack = 1'b1;
      @(negedge clk);
      mul_ab_ack = 1'b0;
      chk("waitz_stb_drop", mul_ab_stb, 0);
      chk("waitz_zack",     mul_z_ack,  0);
      mul_z     = z;
      mul_z_stb = 1'b1;
      @(negedge clk);
      mul_z_stb = 1'b0;
      mul_z     = '0;
      chk("resp_rsp_valid", rsp_valid, oh);
      chk("resp_rsp_z",     rsp_z,     z);
      chk("resp_zack",      mul_z_ack, 1);
      for (int i = 0; i < rsp_dly; i++) begin
         rsp_ready = ~oh;
         @(negedge clk);
         chk("bp_rsp_valid", rsp_valid, oh);
         chk("bp_rsp_z",     rsp_z,     z);
         chk("bp_zack",      mul_z_ack, 0);
         chk("bp_req_ready", req_ready, 0);
         chk("bp_busy",      busy,      1);
      end
      rsp_ready = oh;
      @(negedge clk);
      rsp_ready = '0;
      chk("done_rsp_valid", rsp_valid, 0);
      chk("done_busy",      busy,      0);
      chk("done_zack",      mul_z_ack, 0);
   endtask

   initial begin
      rstn       = 1'b0;
      req_a      = '0;
      req_b      = '0;
      req_valid  = '0;
      rsp_ready  = '0;
      mul_ab_ack = 1'b0;
      mul_z      = '0;
      mul_z_stb  = 1'b0;

      // Reset state
      @(negedge clk);
      check_reset_outputs("reset");
      rstn = 1'b1;
      @(negedge clk);

      // Single request on port 0: 2.0 * 3.0 = 6.0
      set_op(0, 32'h4000_0000, 32'h4040_0000);
      req_valid = 4'b0001;
      run_op(0, 32'h40C0_0000, 0, 0, 1'b1);

      // All four requesting from reset
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      set_op(0, 32'h3F80_0000, 32'h4000_0000);
      set_op(1, 32'h4000_0000, 32'h4000_0000);
      set_op(2, 32'h4040_0000, 32'h4000_0000);
      set_op(3, 32'h4080_0000, 32'h4000_0000);
      req_valid = 4'b1111;
`ifdef FMUL_ARB_RR_EN
      run_op(0, 32'h4000_0000, 0, 0, 1'b0);
      run_op(1, 32'h4080_0000, 0, 0, 1'b0);
      run_op(2, 32'h40C0_0000, 0, 0, 1'b0);
      run_op(3, 32'h4100_0000, 0, 0, 1'b0);
      run_op(0, 32'h4000_0000, 0, 0, 1'b0);
`else
      run_op(0, 32'h4000_0000, 0, 0, 1'b0);
      run_op(0, 32'h4000_0000, 0, 0, 1'b0);
      run_op(0, 32'h4000_0000, 0, 0, 1'b0);
`endif
      req_valid = '0;

      // Backpressure on port 2: -1.0 * 5.0 = -5.0, response held 10 cycles
      set_op(2, 32'hBF80_0000, 32'h40A0_0000);
      req_valid = 4'b0100;
      run_op(2, 32'hC0A0_0000, 0, 10, 1'b1);

      // Slow core on port 1: 2.0 * 2.0 = 4.0, ack delayed 5 cycles
      set_op(1, 32'h4000_0000, 32'h4000_0000);
      req_valid = 4'b0010;
      run_op(1, 32'h4080_0000, 5, 0, 1'b1);

      // Reset while waiting for the product of port 3
      set_op(3, 32'h4040_0000, 32'h4040_0000);
      req_valid = 4'b1000;
      @(negedge clk);
      req_valid  = '0;
      mul_ab_ack = 1'b1;
      @(negedge clk);
      mul_ab_ack = 1'b0;
      chk("pre_reset_busy", busy, 1);
      chk("pre_reset_grant_id", grant_id, 3);
      #2 rstn = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("post_reset_rsp_valid", rsp_valid, 0);

      // Port 1 after reset: 2.0 * 5.0 = 10.0
      set_op(1, 32'h4000_0000, 32'h40A0_0000);
      req_valid = 4'b0010;
      run_op(1, 32'h4120_0000, 0, 0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
